// File: rtl/alu_dispatch.sv
// Decode/dispatch front end for a combinational RV32 ALU: accepts one request,
// holds operands and a one-hot op through EXEC, then presents the response.
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | operands and op driven to the ALU, down-counter running
// RESP  | response held until rsp_ready
module alu_dispatch #(
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [15:0] alu_instructions,
    input  logic [63:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] MD_LOAD = 4'(MULDIV_LAT - 1);

    state_t      state, state_nxt;
    logic [15:0] op_q;
    logic [3:0]  cnt_q;
    logic [15:0] dec_op;
    logic        dec_ill;
    logic [31:0] dec_in2;
    logic        dec_muldiv;
    logic        accept;
    logic [31:0] exec_result;
    logic        unused_hi;

    wire [6:0] opcode = instr[6:0];
    wire [2:0] funct3 = instr[14:12];
    wire [6:0] funct7 = instr[31:25];

    assign unused_hi = ^alu_result[63:32];

    function automatic logic [15:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = 16'd1;
            3'b100:  base_op = 16'd4;
            3'b110:  base_op = 16'd8;
            3'b111:  base_op = 16'd16;
            3'b001:  base_op = 16'd32;
            3'b101:  base_op = 16'd64;
            3'b010:  base_op = 16'd256;
            default: base_op = 16'd512;
        endcase
    endfunction

    always_comb begin
        dec_op  = '0;
        dec_ill = 1'b1;
        dec_in2 = rs2_val;
        case (opcode)
            7'b0110011: begin
                case (funct7)
                    7'b0000000: begin
                        dec_op  = base_op(funct3);
                        dec_ill = 1'b0;
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            dec_op  = 16'd2;
                            dec_ill = 1'b0;
                        end else if (funct3 == 3'b101) begin
                            dec_op  = 16'd128;
                            dec_ill = 1'b0;
                        end
                    end
                    7'b0000001: begin
                        dec_ill = 1'b0;
                        case (funct3)
                            3'b000:  dec_op = 16'd1024;
                            3'b100:  dec_op = 16'd2048;
                            3'b110:  dec_op = 16'd4096;
                            default: dec_ill = 1'b1;
                        endcase
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec_in2 = {{20{instr[31]}}, instr[31:20]};
                // Shift immediates carry funct7 in the upper imm bits; only srai may set bit 30
                case (funct3)
                    3'b001: begin
                        if (funct7 == 7'b0000000) begin
                            dec_op  = 16'd32;
                            dec_ill = 1'b0;
                        end
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000) begin
                            dec_op  = 16'd64;
                            dec_ill = 1'b0;
                        end else if (funct7 == 7'b0100000) begin
                            dec_op  = 16'd128;
                            dec_ill = 1'b0;
                        end
                    end
                    default: begin
                        dec_op  = base_op(funct3);
                        dec_ill = 1'b0;
                    end
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign dec_muldiv = |dec_op[12:10];
    assign accept     = req_valid && (state == IDLE);

    // Divide-by-zero results follow RISC-V semantics regardless of the ALU
    always_comb begin
        exec_result = alu_result[31:0];
        if (op_q[11] && (alu_in2 == '0))
            exec_result = 32'hFFFF_FFFF;
        else if (op_q[12] && (alu_in2 == '0))
            exec_result = alu_in1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            rsp_data    <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q        <= dec_ill ? 16'd0 : dec_op;
                alu_in1     <= rs1_val;
                alu_in2     <= dec_in2;
                cnt_q       <= dec_muldiv ? MD_LOAD : 4'd0;
                rsp_illegal <= dec_ill;
                rsp_data    <= '0;
            end else if (state == EXEC) begin
                if (cnt_q == 4'd0)
                    rsp_data <= exec_result;
                else
                    cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        alu_instructions = '0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid)
                    state_nxt = dec_ill ? RESP : EXEC;
            end
            EXEC: begin
                alu_instructions = op_q;
                if (cnt_q == 4'd0)
                    state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch with a behavioural ALU on the far side.
module tb_alu_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [15:0] alu_instructions;
    logic [63:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [15:0] op;
        int          exec;
        logic [31:0] in2;
        logic [31:0] data;
        logic        ill;
        int          lat;
        int          hold;
    } txn_t;

    txn_t sb[$];

    alu_dispatch #(.MULDIV_LAT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .instr            (instr),
        .rs1_val          (rs1_val),
        .rs2_val          (rs2_val),
        .alu_in1          (alu_in1),
        .alu_in2          (alu_in2),
        .alu_instructions (alu_instructions),
        .alu_result       (alu_result),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_illegal      (rsp_illegal)
    );

    always #5 clk = ~clk;

    // External ALU; divide-by-zero returns junk so the dispatcher's override is visible
    logic signed [31:0] sa, sb_op;
    assign sa    = alu_in1;
    assign sb_op = alu_in2;
    always_comb begin
        alu_result = '0;
        case (alu_instructions)
            16'd1:    alu_result = {32'd0, alu_in1 + alu_in2};
            16'd2:    alu_result = {32'd0, alu_in1 - alu_in2};
            16'd4:    alu_result = {32'd0, alu_in1 ^ alu_in2};
            16'd8:    alu_result = {32'd0, alu_in1 | alu_in2};
            16'd16:   alu_result = {32'd0, alu_in1 & alu_in2};
            16'd32:   alu_result = {32'd0, alu_in1 << alu_in2[4:0]};
            16'd64:   alu_result = {32'd0, alu_in1 >> alu_in2[4:0]};
            16'd128:  alu_result = {32'd0, 32'(sa >>> alu_in2[4:0])};
            16'd256:  alu_result = {63'd0, sa < sb_op};
            16'd512:  alu_result = {63'd0, alu_in1 < alu_in2};
            16'd1024: alu_result = 64'(sa) * 64'(sb_op);
            16'd2048: alu_result = (alu_in2 == 0) ? 64'h1234_5678 : {32'd0, 32'(sa / sb_op)};
            16'd4096: alu_result = (alu_in2 == 0) ? 64'h5555_5555 : {32'd0, 32'(sa % sb_op)};
            default:  alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, exp);
        end
    endtask

    task automatic collect();
        txn_t        t;
        int          lat = 1;
        int          ex  = 0;
        bit          got = 0;
        logic [15:0] op_seen  = '0;
        logic [31:0] in2_seen = '0;
        logic [31:0] in1_seen = '0;
        t = sb.pop_front();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
            if (alu_instructions != 0) begin
                if (ex == 0) begin
                    op_seen  = alu_instructions;
                    in1_seen = alu_in1;
                    in2_seen = alu_in2;
                end else begin
                    chk("exec_op_stable", alu_instructions, op_seen);
                    chk("exec_in1_stable", alu_in1, in1_seen);
                    chk("exec_in2_stable", alu_in2, in2_seen);
                end
                ex++;
            end
            lat++;
        end
        chk("rsp_arrived", got, 1);
        chk("latency", lat, t.lat);
        chk("exec_cycles", ex, t.exec);
        chk("alu_op", op_seen, t.op);
        if (t.exec > 0) begin
            chk("alu_in1", in1_seen, t.rs1);
            chk("alu_in2", in2_seen, t.in2);
        end
        chk("rsp_data", rsp_data, t.data);
        chk("rsp_illegal", rsp_illegal, t.ill);
        chk("idle_op_zero", alu_instructions, 0);
        for (int i = 0; i < t.hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, t.data);
            chk("hold_illegal", rsp_illegal, t.ill);
            chk("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("release_valid", rsp_valid, 0);
        chk("release_req_ready", req_ready, 1);
    endtask

    task automatic send(input logic [31:0] i_instr, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] op, input int exec, input logic [31:0] in2,
                        input logic [31:0] data, input logic ill, input int lat, input int hold);
        txn_t t;
        t.instr = i_instr; t.rs1 = a; t.rs2 = b; t.op = op; t.exec = exec;
        t.in2 = in2; t.data = data; t.ill = ill; t.lat = lat; t.hold = hold;
        sb.push_back(t);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        instr     = i_instr;
        rs1_val   = a;
        rs2_val   = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        collect();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        instr     = '0;
        rs1_val   = '0;
        rs2_val   = '0;
        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_illegal", rsp_illegal, 0);
        chk("rst_alu_in", {alu_in1, alu_in2}, 0);
        chk("rst_alu_op", alu_instructions, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        //   instr         rs1           rs2    op     ex  in2           data          ill lat hold
        send(32'h0000_0033, 32'd5,       32'd7, 16'd1,    1, 32'd7,       32'd12,       0, 2, 0); // add
        send(32'hFFF0_0013, 32'd3,       32'd9, 16'd1,    1, 32'hFFFFFFFF, 32'd2,       0, 2, 0); // addi -1
        send(32'h4000_0033, 32'd10,      32'd3, 16'd2,    1, 32'd3,       32'd7,        0, 2, 0); // sub
        send(32'h4040_5013, 32'h80000000, 32'd0, 16'd128, 1, 32'h404,     32'hF8000000, 0, 2, 0); // srai 4
        send(32'h0000_3033, 32'd1,       32'd2, 16'd512,  1, 32'd2,       32'd1,        0, 2, 0); // sltu
        send(32'h0200_0033, 32'd6,       32'd7, 16'd1024, 4, 32'd7,       32'd42,       0, 5, 0); // mul
        send(32'h0200_4033, 32'd100,     32'd0, 16'd2048, 4, 32'd0,       32'hFFFFFFFF, 0, 5, 0); // div /0
        send(32'h0200_6033, 32'd100,     32'd0, 16'd4096, 4, 32'd0,       32'd100,      0, 5, 0); // rem /0
        send(32'h0200_4033, 32'd100,     32'd7, 16'd2048, 4, 32'd7,       32'd14,       0, 5, 0); // div
        send(32'h0000_007F, 32'd1,       32'd2, 16'd0,    0, 32'd0,       32'd0,        1, 1, 0); // bad opcode
        send(32'h0200_1033, 32'd1,       32'd2, 16'd0,    0, 32'd0,       32'd0,        1, 1, 0); // mulh
        send(32'h0000_4033, 32'hF0,      32'hFF, 16'd4,   1, 32'hFF,      32'h0F,       0, 2, 5); // xor, stalled

        // Abort a div mid-EXEC with an asynchronous reset pulse
        @(negedge clk);
        instr     = 32'h0200_4033;
        rs1_val   = 32'd100;
        rs2_val   = 32'd7;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_exec", alu_instructions, 16'd2048);
        #2 rst = 1'b1;
        #1;
        chk("abort_alu_op", alu_instructions, 0);
        chk("abort_alu_in", {alu_in1, alu_in2}, 0);
        chk("abort_rsp", {rsp_valid, rsp_illegal, rsp_data}, 0);
        chk("abort_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 1);
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_valid = 1;
        end
        chk("abort_no_rsp", seen_valid, 0);
        send(32'h0000_0033, 32'd20, 32'd22, 16'd1, 1, 32'd22, 32'd42, 0, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
